qam_mapper: RTL and testbench

QAM_MAPPER -- requirements
Module: qam_mapper

---
 rtl/qam_mapper.sv | 166 ++++++++++++++++
 tb/tb_qam_mapper.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/qam_mapper.sv
// ---------------------------------------------------------------------------
// qam_mapper
//   Serialises a DATA_W-bit input word (LSB first) into BPSK / QPSK / 16QAM /
//   64QAM constellation symbols. Each axis is mapped to an odd multiple of
//   D = 2^(IQ_W-4): level = (2m - (L-1)) * D.
//
//   Ports
//     clk      in   clock, rising edge
//     rst      in   synchronous, active-high reset
//     s_data   in   [DATA_W-1:0] input word, sent LSB first
//     s_valid  in   s_data valid
//     s_ready  out  word accepted this cycle when s_valid is also high
//     mode     in   [1:0] 0=BPSK 1=QPSK 2=16QAM 3=64QAM (latched per word)
//     m_i      out  signed [IQ_W-1:0] in-phase sample
//     m_q      out  signed [IQ_W-1:0] quadrature sample
//     m_valid  out  symbol valid
//     m_ready  in   downstream accepts symbol
//     m_last   out  final symbol of the current word
//     error    out  sticky: mode input changed while a word was in flight
//
//   Build option
//     GRAY_MAP_EN  when defined, the axis bits are Gray coded (the axis index
//                  is the Gray-to-binary of the bits); otherwise natural binary.
// ---------------------------------------------------------------------------
module qam_mapper #(
  parameter int DATA_W = 32,
  parameter int IQ_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [1:0]             mode,
  output logic signed [IQ_W-1:0] m_i,
  output logic signed [IQ_W-1:0] m_q,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   error
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   sh_q;
  logic [1:0]          mode_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                error_q;

  logic                accept;
  logic                adv;
  logic signed [IQ_W-1:0] i_lvl;
  logic signed [IQ_W-1:0] q_lvl;

  // Symbols per word, ceil(DATA_W / k).
  function automatic logic [CNT_W-1:0] n_sym(input logic [1:0] md);
    logic [CNT_W-1:0] n;
    case (md)
      2'd0:    n = CNT_W'(DATA_W);
      2'd1:    n = CNT_W'((DATA_W + 1) / 2);
      2'd2:    n = CNT_W'((DATA_W + 3) / 4);
      default: n = CNT_W'((DATA_W + 5) / 6);
    endcase
    return n;
  endfunction

  // Bits consumed per symbol.
  function automatic logic [2:0] bits_per_sym(input logic [1:0] md);
    logic [2:0] k;
    case (md)
      2'd0:    k = 3'd1;
      2'd1:    k = 3'd2;
      2'd2:    k = 3'd4;
      default: k = 3'd6;
    endcase
    return k;
  endfunction

  // One axis level from up to 3 axis bits (unused upper bits are zero) and
  // the number of bits per axis nb (1..3, L = 2^nb).
  function automatic logic signed [IQ_W-1:0] level(input logic [2:0] g,
                                                    input logic [1:0] nb);
    logic [2:0]             m;
    logic [3:0]             l;
    logic [3:0]             lm1;
    logic signed [4:0]      t;
    logic signed [IQ_W-1:0] v;
`ifdef GRAY_MAP_EN
    // Prefix XOR from the MSB; zero upper bits make this valid for any nb.
    m = {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
`else
    m = g;
`endif
    l   = 4'd1 << nb;
    lm1 = l - 4'd1;
    t   = $signed({1'b0, m, 1'b0}) - $signed({1'b0, lm1});
    v   = {{(IQ_W-5){t[4]}}, t};
    return v <<< (IQ_W - 4);
  endfunction

  assign m_valid = (state_q == SHIFT);
  assign m_last  = m_valid && (cnt_q == CNT_W'(1));
  assign s_ready = !m_valid || (m_last && m_ready);
  assign accept  = s_valid && s_ready;
  assign adv     = m_valid && m_ready;
  assign error   = error_q;

  always_comb begin
    i_lvl = '0;
    q_lvl = '0;
    case (mode_q)
      2'd0: begin
        i_lvl = level({2'b00, sh_q[0]}, 2'd1);
      end
      2'd1: begin
        i_lvl = level({2'b00, sh_q[0]}, 2'd1);
        q_lvl = level({2'b00, sh_q[1]}, 2'd1);
      end
      2'd2: begin
        i_lvl = level({1'b0, sh_q[1:0]}, 2'd2);
        q_lvl = level({1'b0, sh_q[3:2]}, 2'd2);
      end
      default: begin
        i_lvl = level(sh_q[2:0], 2'd3);
        q_lvl = level(sh_q[5:3], 2'd3);
      end
    endcase
  end

  // Outputs are zero whenever no symbol is being presented.
  assign m_i = m_valid ? i_lvl : '0;
  assign m_q = m_valid ? q_lvl : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      mode_q  <= 2'd0;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      if (accept) begin
        // Also covers a new word taken on the last-symbol handshake.
        state_q <= SHIFT;
        sh_q    <= s_data;
        mode_q  <= mode;
        cnt_q   <= n_sym(mode);
      end else if (adv) begin
        sh_q  <= sh_q >> bits_per_sym(mode_q);
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_q <= IDLE;
        end
      end
      // A mode presented with a newly accepted word is that word's mode, so
      // it is not a mid-word change.
      if (m_valid && !accept && (mode != mode_q)) begin
        error_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qam_mapper.sv
module tb_qam_mapper;
  localparam int DATA_W = 32;
  localparam int IQ_W   = 16;
`ifdef GRAY_MAP_EN
  localparam longint E16 = 4096;
`else
  localparam longint E16 = 12288;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [DATA_W-1:0]      s_data;
  logic                   s_valid;
  logic                   s_ready;
  logic [1:0]             mode;
  logic signed [IQ_W-1:0] m_i;
  logic signed [IQ_W-1:0] m_q;
  logic                   m_valid;
  logic                   m_ready;
  logic                   m_last;
  logic                   error;

  int checks = 0;
  int errors = 0;

  qam_mapper #(.DATA_W(DATA_W), .IQ_W(IQ_W)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .mode(mode), .m_i(m_i), .m_q(m_q),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Check the presented symbol at a falling edge, then move to the next one.
  task automatic expect_sym(input string tag, input longint ei, input longint eq,
                            input logic elast);
    chk({tag, " valid"}, longint'(m_valid), 1);
    chk({tag, " I"}, longint'(m_i), ei);
    chk({tag, " Q"}, longint'(m_q), eq);
    chk({tag, " last"}, longint'(m_last), longint'(elast));
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] md, input logic [DATA_W-1:0] d);
    mode    = md;
    s_data  = d;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, " m_valid"}, longint'(m_valid), 0);
    chk({tag, " s_ready"}, longint'(s_ready), 1);
  endtask

  initial begin
    logic [31:0] wa;
    logic [31:0] wb;
    logic        b;
    rst = 1'b1; s_data = '0; s_valid = 1'b0; mode = 2'd0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_idle("reset");
    chk("reset m_last", longint'(m_last), 0);
    chk("reset m_i", longint'(m_i), 0);
    chk("reset m_q", longint'(m_q), 0);
    chk("reset error", longint'(error), 0);

    // QPSK 0x00000001
    m_ready = 1'b1;
    send(2'd1, 32'h0000_0001);
    expect_sym("qpsk s1", 4096, -4096, 1'b0);
    for (int i = 2; i <= 16; i++) expect_sym("qpsk", -4096, -4096, i == 16);
    expect_idle("qpsk end");

    // 16QAM all ones
    send(2'd2, 32'hFFFF_FFFF);
    for (int i = 1; i <= 8; i++) expect_sym("16qam ones", E16, E16, i == 8);
    expect_idle("16qam end");

    // 64QAM zeros, last symbol padded
    send(2'd3, 32'h0000_0000);
    for (int i = 1; i <= 6; i++) expect_sym("64qam zero", -28672, -28672, i == 6);
    expect_idle("64qam end");

    // 16QAM with a 5-cycle stall on symbol 3 (nibbles 0,1,4,5,0,0,0,0)
    send(2'd2, 32'h0000_5410);
    expect_sym("stall s1", -12288, -12288, 1'b0);
    expect_sym("stall s2", -4096, -12288, 1'b0);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall hold valid", longint'(m_valid), 1);
      chk("stall hold I", longint'(m_i), -12288);
      chk("stall hold Q", longint'(m_q), -4096);
      chk("stall hold last", longint'(m_last), 0);
      chk("stall s_ready", longint'(s_ready), 0);
      @(negedge clk);
    end
    m_ready = 1'b1;
    expect_sym("stall s3", -12288, -4096, 1'b0);
    expect_sym("stall s4", -4096, -4096, 1'b0);
    for (int i = 5; i <= 8; i++) expect_sym("stall tail", -12288, -12288, i == 8);
    expect_idle("stall end");

    // BPSK back-to-back words
    wa = 32'h0000_0005;
    wb = 32'h8000_0000;
    mode = 2'd0; s_data = wa; s_valid = 1'b1;
    @(negedge clk);
    s_data = wb;
    for (int i = 0; i < 64; i++) begin
      if (i == 32) s_valid = 1'b0;
      b = (i < 32) ? wa[i] : wb[i-32];
      if (i == 31) chk("bpsk b2b s_ready", longint'(s_ready), 1);
      expect_sym("bpsk", b ? 4096 : -4096, 0, (i == 31) || (i == 63));
    end
    expect_idle("bpsk end");

    // Mode toggled mid QPSK word, then reset
    send(2'd1, 32'h0000_0000);
    expect_sym("err s1", -4096, -4096, 1'b0);
    expect_sym("err s2", -4096, -4096, 1'b0);
    mode = 2'd2;
    chk("err before", longint'(error), 0);
    expect_sym("err s3", -4096, -4096, 1'b0);
    chk("err set", longint'(error), 1);
    expect_sym("err s4", -4096, -4096, 1'b0);
    chk("err sticky", longint'(error), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_idle("rst mid");
    chk("rst error", longint'(error), 0);
    chk("rst m_last", longint'(m_last), 0);
    @(negedge clk);
    expect_idle("rst after");

    // New word with a new mode on the last-symbol handshake: no error
    mode = 2'd1; s_data = '0; s_valid = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) mode = 2'd3;
      expect_sym("swap qpsk", -4096, -4096, i == 16);
    end
    s_valid = 1'b0;
    for (int i = 1; i <= 6; i++) expect_sym("swap 64qam", -28672, -28672, i == 6);
    chk("swap error", longint'(error), 0);
    expect_idle("swap end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
